// File: rtl/scr1_sha256_core_if.sv
// Handshake and data bundle between the accelerator register file and the
// SHA-256 compression engine.
interface scr1_sha256_core_if;
  logic         start;
  logic [255:0] state_in;
  logic [511:0] block_in;
  logic         busy;
  logic         done;
  logic [255:0] digest_out;

  modport master (
    output start,
    output state_in,
    output block_in,
    input  busy,
    input  done,
    input  digest_out
  );

  modport slave (
    input  start,
    input  state_in,
    input  block_in,
    output busy,
    output done,
    output digest_out
  );
endinterface

// File: rtl/scr1_sha256_core.sv
// SHA-256 compression engine: one round per cycle, one 512-bit block per start,
// 65 cycles from accepted start to the done pulse.
module scr1_sha256_core #(
  parameter bit ADD_FINAL = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  scr1_sha256_core_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } state_t;

  // Round constants packed with K[0] in the top word.
  localparam logic [2047:0] K_ROM = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] k_at(input logic [5:0] idx);
    return K_ROM[{~idx, 5'd0} +: 32];
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t         state_r;
  state_t         state_next_s;
  logic [5:0]     rnd_r;
  logic [31:0]    a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r;
  logic [255:0]   hh_r;
  logic [511:0]   w_r;
  logic           busy_r;
  logic           done_r;
  logic [255:0]   digest_r;

  logic [31:0]    t1_s;
  logic [31:0]    t2_s;
  logic [31:0]    w_new_s;
  logic [255:0]   digest_next_s;

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.digest_out = digest_r;

  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (rnd_r == 6'd63) begin
          state_next_s = FINAL;
        end else begin
          state_next_s = RUN;
        end
      end
      FINAL:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Window word 0 is W[t]; positions 1, 9 and 14 feed the schedule recurrence.
  always_comb begin
    t1_s    = h_r + bsig1(e_r) + ch(e_r, f_r, g_r) + k_at(rnd_r) + w_r[511:480];
    t2_s    = bsig0(a_r) + maj(a_r, b_r, c_r);
    w_new_s = ssig1(w_r[63:32]) + w_r[223:192] + ssig0(w_r[479:448]) + w_r[511:480];
  end

  always_comb begin
    digest_next_s = 256'd0;
    if (ADD_FINAL) begin
      digest_next_s = {hh_r[255:224] + a_r, hh_r[223:192] + b_r, hh_r[191:160] + c_r, hh_r[159:128] + d_r,
                       hh_r[127:96]  + e_r, hh_r[95:64]    + f_r, hh_r[63:32]    + g_r, hh_r[31:0]     + h_r};
    end else begin
      digest_next_s = {a_r, b_r, c_r, d_r, e_r, f_r, g_r, h_r};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      rnd_r    <= 6'd0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      c_r      <= 32'd0;
      d_r      <= 32'd0;
      e_r      <= 32'd0;
      f_r      <= 32'd0;
      g_r      <= 32'd0;
      h_r      <= 32'd0;
      hh_r     <= 256'd0;
      w_r      <= 512'd0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      digest_r <= 256'd0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != IDLE);
      done_r  <= (state_r == FINAL);
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            hh_r  <= bus.state_in;
            a_r   <= bus.state_in[255:224];
            b_r   <= bus.state_in[223:192];
            c_r   <= bus.state_in[191:160];
            d_r   <= bus.state_in[159:128];
            e_r   <= bus.state_in[127:96];
            f_r   <= bus.state_in[95:64];
            g_r   <= bus.state_in[63:32];
            h_r   <= bus.state_in[31:0];
            w_r   <= bus.block_in;
            rnd_r <= 6'd0;
          end
        end
        RUN: begin
          h_r   <= g_r;
          g_r   <= f_r;
          f_r   <= e_r;
          e_r   <= d_r + t1_s;
          d_r   <= c_r;
          c_r   <= b_r;
          b_r   <= a_r;
          a_r   <= t1_s + t2_s;
          w_r   <= {w_r[479:0], w_new_s};
          rnd_r <= rnd_r + 6'd1;
        end
        FINAL: begin
          digest_r <= digest_next_s;
        end
        default: begin
          rnd_r <= 6'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/scr1_sha256_core.md
# scr1_sha256_core

SHA-256 compression engine for the SCR1 accelerator subsystem. It sits directly downstream of the memory-mapped accelerator register file. It consumes the eight chaining-state words and the sixteen message words that software writes there, runs the 64 SHA-256 rounds, and returns the updated 256-bit chaining value for read-back. One round per cycle; one 512-bit block per start.

## Interface
Parameters:
- ADD_FINAL, default 1: 1 = standard feed-forward (digest = state_in + working vars); 0 = output raw working vars a..h after round 63 (debug only).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request to compress one block; sampled only in IDLE.
- state_in  in  256  chaining value; [255:224]=H0 … [31:0]=H7.
- block_in  in  512  message block; [511:480]=W0 … [31:0]=W15, big-endian words as in FIPS 180-4.
- busy  out  1  high while a block is in flight.
- done  out  1  single-cycle pulse when digest_out is updated.
- digest_out  out  256  result, same word order as state_in; holds until the next completion.

## Operation
- FSM states: IDLE, RUN, FINAL.
- IDLE: on start=1, capture state_in into H0..H7 and into working registers a..h. Capture block_in into a 16-entry W shift window. Clear round counter rnd (6 bits). Go to RUN.
- RUN: each cycle performs round rnd using K[rnd] and Wt, where Wt = window[0].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[rnd] + Wt
  - T2 = Σ0(a) + Maj(a,b,c)
  - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
  - Window shifts by one. The new entry is σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16], taken from window positions 14, 9, 1, 0.
  - rnd increments. When rnd=63, the next state is FINAL.
- FINAL: digest_out ← {H0+a, …, H7+h} when ADD_FINAL=1, else {a..h}. Pulse done. Go to IDLE.
- Function definitions:
  - Σ0 = ROTR2^ROTR13^ROTR22
  - Σ1 = ROTR6^ROTR11^ROTR25
  - σ0 = ROTR7^ROTR18^SHR3
  - σ1 = ROTR17^ROTR19^SHR10
  - Ch = (e&f)^(~e&g)
  - Maj = (a&b)^(a&c)^(b&c)
- Arithmetic: all additions modulo 2^32; carries out of bit 31 are discarded.
- K[0..63]: combinational constant ROM of the 64 FIPS 180-4 round constants, indexed by rnd.
- start while busy=1 or in FINAL: ignored. No queuing, no error flag.
- Inputs are captured at start; state_in/block_in may change freely during RUN without effect.

## Timing
- Reset values:
  - Outputs: busy=0, done=0, digest_out=0.
  - Internal: FSM=IDLE, rnd=0, a..h=0, H0..H7=0, window=0.
- Sequence for start sampled high at edge T:
  - busy=1 from after edge T.
  - Rounds 0..63 occupy edges T+1..T+64.
  - digest_out updates at edge T+65.
  - done=1 for exactly the cycle following edge T+65.
  - busy=0 in that same cycle.
- Latency from start edge to done: 65 cycles. Throughput: one block per 66 cycles; start may be reasserted during the done cycle.
- start held high continuously: a new block begins in each IDLE cycle, i.e. on the done cycle.
- rst_n asserted mid-RUN: immediate return to reset values. No done pulse. digest_out cleared. The next start after release behaves normally.
- done is never asserted without a preceding accepted start.

## Test plan
- Reset: hold rst_n=0 with start=1 and random inputs → busy=0, done=0, digest_out=0. After release with start=0, outputs stay unchanged for 100 cycles.
- "abc" single block:
  - state_in = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - block_in = 61626380, 14×00000000, 00000018.
  - Required: done exactly 65 cycles after start; digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message: same state_in, block_in = 80000000 followed by 15 zero words → digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Busy protection:
  - Pulse start again at cycles T+10 and T+64.
  - Change block_in/state_in during RUN.
  - Required: single done at T+65 with the original "abc" digest; no second done.
- Back-to-back: hold start=1 across two blocks of a two-block message, chaining digest_out into state_in on the done cycle → second done 66 cycles after the first; result matches the reference model ("abcdbcdecdefdefg…nopq" → 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1).
- Mid-run reset: assert rst_n=0 at T+30 for 1 cycle, then start "abc" again → first run produces no done; second run yields the correct digest at 65 cycles after its start.
